// File: rtl/redun_mont_pkg.sv
// Shared types and helpers for the redundant Montgomery datapath.
// Word widths, field/redundant types, chunk carry resolver, reference conversions.
package redun_mont_pkg;

  localparam int WRD_BITS   = 16;
  localparam int NUM_WRDS   = 65;
  localparam int CHUNK_WRDS = 5;
  localparam int DAT_BITS   = NUM_WRDS * WRD_BITS;

  typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;
  typedef logic [DAT_BITS-1:0]             fe_t;

  // Ripple one chunk of redundant words, low to high.
  // Carry peaks at 2: (2^(W+1)-1+2) >> W.
  function automatic void resolve_chunk(
    input  logic [WRD_BITS:0]   w [CHUNK_WRDS],
    input  logic [1:0]          cin,
    output logic [WRD_BITS-1:0] o [CHUNK_WRDS],
    output logic [1:0]          cout
  );
    logic [WRD_BITS+1:0] s;
    logic [1:0]          c;
    c = cin;
    for (int j = 0; j < CHUNK_WRDS; j++) begin
      s    = {1'b0, w[j]} + {{WRD_BITS{1'b0}}, c};
      o[j] = s[WRD_BITS-1:0];
      c    = s[WRD_BITS+1:WRD_BITS];
    end
    cout = c;
  endfunction

  // Full-width weighted sum of all redundant words.
  function automatic logic [DAT_BITS+1:0] redun_sum(input redun0_t r);
    logic [DAT_BITS+1:0] acc;
    logic [DAT_BITS+1:0] t;
    acc = '0;
    for (int i = 0; i < NUM_WRDS; i++) begin
      t              = '0;
      t[WRD_BITS:0]  = r[i];
      acc            = acc + (t << (i * WRD_BITS));
    end
    return acc;
  endfunction

  function automatic fe_t from_redun(input redun0_t r);
    logic [DAT_BITS+1:0] acc;
    acc = redun_sum(r);
    return acc[DAT_BITS-1:0];
  endfunction

  function automatic logic check_overflow(input redun0_t r);
    logic [DAT_BITS+1:0] acc;
    acc = redun_sum(r);
    return acc[DAT_BITS];
  endfunction

endpackage

// File: rtl/redun_carry_resolve.sv
// Word-serial redundant-to-binary converter, CHUNK_WRDS words per cycle.
// Ports: i_clk/i_rst, i_dat/i_val/o_rdy in, o_dat/o_carry/o_ovf/o_val/i_rdy out.
module redun_carry_resolve
  import redun_mont_pkg::*;
(
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_WRDS*(WRD_BITS+1)-1:0] i_dat,
  input  logic                           i_val,
  output logic                           o_rdy,
  output logic [DAT_BITS-1:0]            o_dat,
  output logic [1:0]                     o_carry,
  output logic                           o_ovf,
  output logic                           o_val,
  input  logic                           i_rdy
);

  localparam int IN_BITS    = NUM_WRDS * (WRD_BITS + 1);
  localparam int CHUNK_IN   = CHUNK_WRDS * (WRD_BITS + 1);
  localparam int CHUNK_OUT  = CHUNK_WRDS * WRD_BITS;
  localparam int NUM_CHUNKS = NUM_WRDS / CHUNK_WRDS;
  localparam int CNT_BITS   = $clog2(NUM_CHUNKS + 1);

  if (NUM_WRDS % CHUNK_WRDS != 0) begin : g_bad_chunk
    $fatal(1, "NUM_WRDS must be a multiple of CHUNK_WRDS");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e state_q;
  state_e state_d;

  logic [IN_BITS-1:0]  in_q;
  logic [DAT_BITS-1:0] out_q;
  logic [1:0]          carry_q;
  logic [CNT_BITS-1:0] cnt_q;

  logic [WRD_BITS:0]   w_chk [CHUNK_WRDS];
  logic [WRD_BITS-1:0] o_chk [CHUNK_WRDS];
  logic [CHUNK_OUT-1:0] res_chunk;
  logic [1:0]          c_nxt;

  logic accept;
  logic run;
  logic last;

  assign accept = (state_q == ST_IDLE) && i_val;
  assign run    = (state_q == ST_RUN);
  assign last   = (cnt_q == CNT_BITS'(NUM_CHUNKS - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_val) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_DONE;
      ST_DONE: if (i_rdy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_rdy = (state_q == ST_IDLE);
    o_val = (state_q == ST_DONE);
  end

  always_comb begin
    o_chk     = '{default: '0};
    c_nxt     = '0;
    res_chunk = '0;
    for (int j = 0; j < CHUNK_WRDS; j++) begin
      w_chk[j] = in_q[j*(WRD_BITS+1) +: WRD_BITS+1];
    end
    resolve_chunk(w_chk, carry_q, o_chk, c_nxt);
    for (int j = 0; j < CHUNK_WRDS; j++) begin
      res_chunk[j*WRD_BITS +: WRD_BITS] = o_chk[j];
    end
  end

  // Results enter at the top; after the last chunk, chunk 0 sits at the bottom.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_q    <= '0;
      out_q   <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          in_q    <= i_dat;
          carry_q <= '0;
          cnt_q   <= '0;
        end
        run: begin
          in_q    <= in_q >> CHUNK_IN;
          out_q   <= {res_chunk, out_q[DAT_BITS-1:CHUNK_OUT]};
          carry_q <= c_nxt;
          cnt_q   <= cnt_q + CNT_BITS'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_dat   = out_q;
  assign o_carry = carry_q;
  assign o_ovf   = |carry_q;

endmodule

// File: tb/tb_redun_carry_resolve.sv
// Bench for redun_carry_resolve: directed table, backpressure,
// mid-run reset and random vectors against from_redun/check_overflow.
module tb_redun_carry_resolve;
  import redun_mont_pkg::*;

  logic       clk = 1'b0;
  logic       i_rst;
  redun0_t    i_dat;
  logic       i_val;
  logic       o_rdy;
  fe_t        o_dat;
  logic [1:0] o_carry;
  logic       o_ovf;
  logic       o_val;
  logic       i_rdy;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  redun_carry_resolve dut (
    .i_clk  (clk),
    .i_rst  (i_rst),
    .i_dat  (i_dat),
    .i_val  (i_val),
    .o_rdy  (o_rdy),
    .o_dat  (o_dat),
    .o_carry(o_carry),
    .o_ovf  (o_ovf),
    .o_val  (o_val),
    .i_rdy  (i_rdy)
  );

  typedef struct {
    string      nm;
    redun0_t    din;
    fe_t        dat;
    logic [1:0] car;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input fe_t act, input fe_t exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      for (int k = 0; k < NUM_WRDS; k++) begin
        if (act[k*WRD_BITS +: WRD_BITS] !== exp[k*WRD_BITS +: WRD_BITS]) begin
          $display("FAIL %s: word %0d got %h want %h", nm, k,
                   act[k*WRD_BITS +: WRD_BITS], exp[k*WRD_BITS +: WRD_BITS]);
          break;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for o_rdy, present d for one accepting edge; returns in cycle 1.
  task automatic send(input redun0_t d);
    int n = 0;
    while (!o_rdy && n < 50) begin
      tick();
      n++;
    end
    chk("send_rdy", 64'(o_rdy), 64'd1);
    i_dat = d;
    i_val = 1'b1;
    tick();
    i_val = 1'b0;
  endtask

  // Counts cycles from accept (cycle 0) to first o_val.
  task automatic wait_val(output int lat, output bit rdy_low);
    lat     = 1;
    rdy_low = 1'b1;
    while (!o_val && lat < 60) begin
      if (o_rdy) rdy_low = 1'b0;
      tick();
      lat++;
    end
    if (o_rdy) rdy_low = 1'b0;
  endtask

  initial begin
    int      lat;
    bit      rl;
    bit      stable;
    bit      seen;
    fe_t     d0;
    logic [1:0] c0;
    redun0_t r;
    int      mode;

    vt[0].nm  = "zero";
    vt[0].din = '0;
    vt[0].dat = '0;
    vt[0].car = 2'd0;

    vt[1].nm     = "w0_bit16";
    vt[1].din    = '0;
    vt[1].din[0] = 17'h10000;
    vt[1].dat    = '0;
    vt[1].dat[16] = 1'b1;
    vt[1].car    = 2'd0;

    vt[2].nm = "ripple_all";
    for (int k = 0; k < NUM_WRDS; k++) vt[2].din[k] = 17'h0FFFF;
    vt[2].din[0]     = 17'h1FFFF;
    vt[2].dat        = '0;
    vt[2].dat[15:0]  = 16'hFFFF;
    vt[2].car        = 2'd1;

    vt[3].nm      = "top_max";
    vt[3].din     = '0;
    vt[3].din[64] = 17'h1FFFF;
    vt[3].dat     = '0;
    vt[3].dat[DAT_BITS-1:DAT_BITS-16] = 16'hFFFF;
    vt[3].car     = 2'd1;

    vt[4].nm      = "top2_max";
    vt[4].din     = '0;
    vt[4].din[63] = 17'h1FFFF;
    vt[4].din[64] = 17'h1FFFF;
    vt[4].dat     = '0;
    vt[4].dat[1023:1008] = 16'hFFFF;
    vt[4].car     = 2'd2;

    i_rst = 1'b1;
    i_val = 1'b0;
    i_rdy = 1'b1;
    i_dat = '0;
    repeat (3) tick();
    chk("rst_rdy", 64'(o_rdy), 64'd1);
    chk("rst_val", 64'(o_val), 64'd0);
    chkw("rst_dat", o_dat, '0);
    chk("rst_carry", 64'(o_carry), 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    i_rst = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      send(vt[v].din);
      wait_val(lat, rl);
      chk({vt[v].nm, "_lat"}, 64'(lat), 64'd14);
      chk({vt[v].nm, "_rdy_low"}, 64'(rl), 64'd1);
      chkw({vt[v].nm, "_dat"}, o_dat, vt[v].dat);
      chk({vt[v].nm, "_carry"}, 64'(o_carry), 64'(vt[v].car));
      chk({vt[v].nm, "_ovf"}, 64'(o_ovf), 64'(vt[v].car != 2'd0));
      tick();
      chk({vt[v].nm, "_rdy_back"}, 64'(o_rdy), 64'd1);
      chk({vt[v].nm, "_val_drop"}, 64'(o_val), 64'd0);
    end

    // Backpressure with a second request pending.
    i_rdy = 1'b0;
    send(vt[2].din);
    wait_val(lat, rl);
    chk("bp_lat", 64'(lat), 64'd14);
    d0     = o_dat;
    c0     = o_carry;
    i_dat  = vt[1].din;
    i_val  = 1'b1;
    stable = 1'b1;
    repeat (10) begin
      tick();
      if (o_dat !== d0 || o_carry !== c0 || !o_val || o_rdy) stable = 1'b0;
    end
    chk("bp_stable", 64'(stable), 64'd1);
    chkw("bp_dat", o_dat, vt[2].dat);
    chk("bp_carry", 64'(o_carry), 64'd1);
    i_rdy = 1'b1;
    tick();
    chk("bp_rdy_after", 64'(o_rdy), 64'd1);
    chk("bp_val_after", 64'(o_val), 64'd0);
    tick();
    i_val = 1'b0;
    wait_val(lat, rl);
    chk("bp2_lat", 64'(lat), 64'd14);
    chkw("bp2_dat", o_dat, vt[1].dat);
    chk("bp2_carry", 64'(o_carry), 64'd0);
    tick();

    // Reset in RUN cycle 6.
    send(vt[2].din);
    repeat (5) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("mid_rst_val", 64'(o_val), 64'd0);
    chk("mid_rst_rdy", 64'(o_rdy), 64'd1);
    chk("mid_rst_carry", 64'(o_carry), 64'd0);
    chkw("mid_rst_dat", o_dat, '0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (o_val) seen = 1'b1;
    end
    chk("mid_rst_no_stale", 64'(seen), 64'd0);

    for (int n = 0; n < 1000; n++) begin
      mode = $urandom_range(0, 3);
      for (int k = 0; k < NUM_WRDS; k++) begin
        unique case (mode)
          0: r[k] = (WRD_BITS+1)'($urandom);
          1: r[k] = {1'b0, WRD_BITS'($urandom)};
          2: r[k] = $urandom_range(0, 1) ? 17'h1FFFF : 17'h0FFFF;
          default: r[k] = $urandom_range(0, 7) == 0 ? 17'h1FFFF
                                                     : (WRD_BITS+1)'($urandom);
        endcase
      end
      send(r);
      wait_val(lat, rl);
      chk("rnd_lat", 64'(lat), 64'd14);
      chkw("rnd_dat", o_dat, from_redun(r));
      chk("rnd_carry0", 64'(o_carry[0]), 64'(check_overflow(r)));
      chk("rnd_ovf", 64'(o_ovf), 64'(|o_carry));
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
